// File: rtl/axil_bar_decoder.sv
// AXI4-Lite BAR address decoder: one master fanned out to NUM_SLAVES register slaves.
// Independent write/read engines, DECERR for unmapped windows, SLVERR on slave timeout.
module axil_bar_decoder #(
    parameter int NUM_SLAVES      = 2,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT         = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                m_awaddr,
    input  logic                       m_awvalid,
    output logic                       m_awready,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wstrb,
    input  logic                       m_wvalid,
    output logic                       m_wready,
    output logic [1:0]                 m_bresp,
    output logic                       m_bvalid,
    input  logic                       m_bready,
    input  logic [31:0]                m_araddr,
    input  logic                       m_arvalid,
    output logic                       m_arready,
    output logic [31:0]                m_rdata,
    output logic [1:0]                 m_rresp,
    output logic                       m_rvalid,
    input  logic                       m_rready,
    output logic [32*NUM_SLAVES-1:0]   s_awaddr,
    output logic [NUM_SLAVES-1:0]      s_awvalid,
    input  logic [NUM_SLAVES-1:0]      s_awready,
    output logic [32*NUM_SLAVES-1:0]   s_wdata,
    output logic [4*NUM_SLAVES-1:0]    s_wstrb,
    output logic [NUM_SLAVES-1:0]      s_wvalid,
    input  logic [NUM_SLAVES-1:0]      s_wready,
    input  logic [2*NUM_SLAVES-1:0]    s_bresp,
    input  logic [NUM_SLAVES-1:0]      s_bvalid,
    output logic [NUM_SLAVES-1:0]      s_bready,
    output logic [32*NUM_SLAVES-1:0]   s_araddr,
    output logic [NUM_SLAVES-1:0]      s_arvalid,
    input  logic [NUM_SLAVES-1:0]      s_arready,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    input  logic [2*NUM_SLAVES-1:0]    s_rresp,
    input  logic [NUM_SLAVES-1:0]      s_rvalid,
    output logic [NUM_SLAVES-1:0]      s_rready,
    output logic                       timeout_pulse
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_BACK} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_BACK} rstate_t;

    // The whole upper address is compared, so windows beyond NUM_SLAVES never alias a real slave.
    function automatic logic is_mapped(input logic [31:0] a);
        return (32'(a >> SLAVE_ADDR_BITS) < 32'(NUM_SLAVES));
    endfunction

    wstate_t                    r_wstate;
    logic                       r_aw_held, r_w_held, r_aw_done, r_w_done;
    logic [31:0]                r_awaddr, r_wdata;
    logic [3:0]                 r_wstrb;
    logic [IDX_W-1:0]           r_wsel;
    logic [1:0]                 r_bresp;
    logic [31:0]                r_wcnt;

    rstate_t                    r_rstate;
    logic [SLAVE_ADDR_BITS-1:0] r_araddr;
    logic [IDX_W-1:0]           r_rsel;
    logic [31:0]                r_rdata;
    logic [1:0]                 r_rresp;
    logic [31:0]                r_rcnt;

    logic                       r_tpulse;
    logic                       r_live;

    logic        w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_req_done;
    logic        w_wto_hit, w_rto_hit, w_wto_fire, w_rto_fire;
    logic [31:0] w_awaddr_n;

    assign m_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign m_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign m_bvalid  = (r_wstate == W_BACK);
    assign m_bresp   = r_bresp;
    assign m_arready = (r_rstate == R_IDLE);
    assign m_rvalid  = (r_rstate == R_BACK);
    assign m_rdata   = r_rdata;
    assign m_rresp   = r_rresp;
    assign timeout_pulse = r_tpulse;

    assign w_aw_hs    = m_awvalid && m_awready;
    assign w_w_hs     = m_wvalid && m_wready;
    assign w_aw_have  = r_aw_held || w_aw_hs;
    assign w_w_have   = r_w_held || w_w_hs;
    assign w_awaddr_n = r_aw_held ? r_awaddr : m_awaddr;
    assign w_req_done = (r_aw_done || s_awready[r_wsel]) && (r_w_done || s_wready[r_wsel]);

    assign w_wto_hit  = (TIMEOUT != 0) && (r_wcnt == 32'(TIMEOUT - 1));
    assign w_rto_hit  = (TIMEOUT != 0) && (r_rcnt == 32'(TIMEOUT - 1));
    // A slave response in the expiry cycle takes precedence over the timeout.
    assign w_wto_fire = w_wto_hit && (((r_wstate == W_REQ) && !w_req_done) ||
                                      ((r_wstate == W_RESP) && !s_bvalid[r_wsel]));
    assign w_rto_fire = w_rto_hit && (((r_rstate == R_REQ) && !s_arready[r_rsel]) ||
                                      ((r_rstate == R_WAIT) && !s_rvalid[r_rsel]));

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
        assign s_awvalid[g]        = (r_wstate == W_REQ) && (r_wsel == IDX_W'(g)) && !r_aw_done;
        assign s_wvalid[g]         = (r_wstate == W_REQ) && (r_wsel == IDX_W'(g)) && !r_w_done;
        assign s_awaddr[g*32 +: 32] = 32'(r_awaddr[SLAVE_ADDR_BITS-1:0]);
        assign s_wdata[g*32 +: 32]  = r_wdata;
        assign s_wstrb[g*4 +: 4]    = r_wstrb;
        assign s_arvalid[g]        = (r_rstate == R_REQ) && (r_rsel == IDX_W'(g));
        assign s_araddr[g*32 +: 32] = 32'(r_araddr);
        // Responses are always accepted; only the awaited one is forwarded, late ones drain away.
        assign s_bready[g]         = r_live;
        assign s_rready[g]         = r_live;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_live   <= 1'b0;
            r_tpulse <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            r_tpulse <= w_wto_fire || w_rto_fire;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wsel    <= '0;
            r_bresp   <= 2'b00;
            r_wcnt    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= m_awaddr;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= m_wdata;
                        r_wstrb  <= m_wstrb;
                        r_w_held <= 1'b1;
                    end
                    if (w_aw_have && w_w_have) begin
                        if (!is_mapped(w_awaddr_n)) begin
                            r_bresp  <= 2'b11;
                            r_wstate <= W_BACK;
                        end else begin
                            r_wsel    <= w_awaddr_n[SLAVE_ADDR_BITS +: IDX_W];
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_wcnt    <= '0;
                            r_wstate  <= W_REQ;
                        end
                    end
                end
                W_REQ: begin
                    r_wcnt <= r_wcnt + 32'd1;
                    if (s_awready[r_wsel]) r_aw_done <= 1'b1;
                    if (s_wready[r_wsel])  r_w_done  <= 1'b1;
                    if (w_req_done) begin
                        r_wstate <= W_RESP;
                    end else if (w_wto_fire) begin
                        r_bresp  <= 2'b10;
                        r_wstate <= W_BACK;
                    end
                end
                W_RESP: begin
                    r_wcnt <= r_wcnt + 32'd1;
                    if (s_bvalid[r_wsel]) begin
                        r_bresp  <= s_bresp[r_wsel*2 +: 2];
                        r_wstate <= W_BACK;
                    end else if (w_wto_fire) begin
                        r_bresp  <= 2'b10;
                        r_wstate <= W_BACK;
                    end
                end
                W_BACK: begin
                    if (m_bready) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_araddr <= '0;
            r_rsel   <= '0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
            r_rcnt   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (m_arvalid) begin
                        if (!is_mapped(m_araddr)) begin
                            r_rdata  <= '0;
                            r_rresp  <= 2'b11;
                            r_rstate <= R_BACK;
                        end else begin
                            r_araddr <= m_araddr[SLAVE_ADDR_BITS-1:0];
                            r_rsel   <= m_araddr[SLAVE_ADDR_BITS +: IDX_W];
                            r_rcnt   <= '0;
                            r_rstate <= R_REQ;
                        end
                    end
                end
                R_REQ: begin
                    r_rcnt <= r_rcnt + 32'd1;
                    if (s_arready[r_rsel]) begin
                        r_rstate <= R_WAIT;
                    end else if (w_rto_fire) begin
                        r_rdata  <= 32'hDEAD_BEEF;
                        r_rresp  <= 2'b10;
                        r_rstate <= R_BACK;
                    end
                end
                R_WAIT: begin
                    r_rcnt <= r_rcnt + 32'd1;
                    if (s_rvalid[r_rsel]) begin
                        r_rdata  <= s_rdata[r_rsel*32 +: 32];
                        r_rresp  <= s_rresp[r_rsel*2 +: 2];
                        r_rstate <= R_BACK;
                    end else if (w_rto_fire) begin
                        r_rdata  <= 32'hDEAD_BEEF;
                        r_rresp  <= 2'b10;
                        r_rstate <= R_BACK;
                    end
                end
                R_BACK: begin
                    if (m_rready) r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule
